// File: rtl/muldiv_ctrl.sv
// Iterative HI/LO multiply-divide unit: 32 radix-2 steps plus one sign-fixup cycle.
// Owns the architectural HI/LO registers and raises stall requests for the hazard unit.
module muldiv_ctrl (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start_md_i,
  input  logic [1:0]  op_md_i,
  input  logic [31:0] src_a_md_i,
  input  logic [31:0] src_b_md_i,
  input  logic        mthi_md_i,
  input  logic        mtlo_md_i,
  input  logic [31:0] wr_data_md_i,
  input  logic        rd_hilo_md_i,
  input  logic        flush_md_i,
  output logic        busy_md_o,
  output logic        stall_md_o,
  output logic        done_md_o,
  output logic        div_by_zero_md_o,
  output logic [31:0] hi_md_o,
  output logic [31:0] lo_md_o
);

  typedef enum logic [1:0] {IDLE, CALC, FIXUP} state_e;

  state_e      state_q, state_d;
  logic [4:0]  cnt_q, cnt_d;
  logic        is_div_q, is_div_d;
  logic        neg_q, neg_d;
  logic        rem_neg_q, rem_neg_d;
  logic        dbz_q, dbz_d;
  logic [31:0] m_q, m_d;
  logic [63:0] p_q, p_d;
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;
  logic        done_q, done_d;
  logic        dbz_out_q, dbz_out_d;

  logic        a_neg, b_neg;
  logic [31:0] a_mag, b_mag;
  logic [32:0] mul_sum;
  logic [63:0] mul_next;
  logic [32:0] div_shift;
  logic        div_ge;
  logic [32:0] div_rem;
  logic [63:0] div_next;
  logic [63:0] prod_fix;
  logic [31:0] quo_fix, rem_fix;

  // MULT and DIV (op[0]==0) are the signed flavours.
  assign a_neg = ~op_md_i[0] & src_a_md_i[31];
  assign b_neg = ~op_md_i[0] & src_b_md_i[31];
  assign a_mag = a_neg ? -src_a_md_i : src_a_md_i;
  assign b_mag = b_neg ? -src_b_md_i : src_b_md_i;

  // Multiply: p holds {partial product, remaining multiplier bits}.
  assign mul_sum  = {1'b0, p_q[63:32]} + (p_q[0] ? {1'b0, m_q} : 33'd0);
  assign mul_next = {mul_sum, p_q[31:1]};

  // Divide: p holds {partial remainder, dividend bits shifting into quotient}.
  assign div_shift = {p_q[63:32], p_q[31]};
  assign div_ge    = div_shift >= {1'b0, m_q};
  assign div_rem   = div_ge ? (div_shift - {1'b0, m_q}) : div_shift;
  assign div_next  = {div_rem[31:0], p_q[30:0], div_ge};

  assign prod_fix = neg_q ? -p_q : p_q;
  assign quo_fix  = dbz_q ? 32'hFFFF_FFFF : (neg_q ? -p_q[31:0] : p_q[31:0]);
  assign rem_fix  = rem_neg_q ? -p_q[63:32] : p_q[63:32];

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    is_div_d  = is_div_q;
    neg_d     = neg_q;
    rem_neg_d = rem_neg_q;
    dbz_d     = dbz_q;
    m_d       = m_q;
    p_d       = p_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    done_d    = 1'b0;
    dbz_out_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (start_md_i && !flush_md_i) begin
          state_d   = CALC;
          cnt_d     = 5'd31;
          is_div_d  = op_md_i[1];
          neg_d     = a_neg ^ b_neg;
          rem_neg_d = a_neg;
          dbz_d     = op_md_i[1] & (src_b_md_i == 32'd0);
          m_d       = op_md_i[1] ? b_mag : a_mag;
          p_d       = {32'd0, op_md_i[1] ? a_mag : b_mag};
        end else begin
          if (mthi_md_i) hi_d = wr_data_md_i;
          if (mtlo_md_i) lo_d = wr_data_md_i;
        end
      end
      CALC: begin
        if (flush_md_i) begin
          state_d = IDLE;
        end else begin
          p_d = is_div_q ? div_next : mul_next;
          if (cnt_q == 5'd0) state_d = FIXUP;
          else               cnt_d   = cnt_q - 5'd1;
        end
      end
      FIXUP: begin
        state_d = IDLE;
        if (!flush_md_i) begin
          hi_d      = is_div_q ? rem_fix : prod_fix[63:32];
          lo_d      = is_div_q ? quo_fix : prod_fix[31:0];
          done_d    = 1'b1;
          dbz_out_d = dbz_q;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cnt_q     <= 5'd0;
      is_div_q  <= 1'b0;
      neg_q     <= 1'b0;
      rem_neg_q <= 1'b0;
      dbz_q     <= 1'b0;
      m_q       <= 32'd0;
      p_q       <= 64'd0;
      hi_q      <= 32'd0;
      lo_q      <= 32'd0;
      done_q    <= 1'b0;
      dbz_out_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      is_div_q  <= is_div_d;
      neg_q     <= neg_d;
      rem_neg_q <= rem_neg_d;
      dbz_q     <= dbz_d;
      m_q       <= m_d;
      p_q       <= p_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      done_q    <= done_d;
      dbz_out_q <= dbz_out_d;
    end
  end

  assign busy_md_o        = (state_q != IDLE);
  assign stall_md_o       = busy_md_o & (start_md_i | rd_hilo_md_i | mthi_md_i | mtlo_md_i);
  assign done_md_o        = done_q;
  assign div_by_zero_md_o = dbz_out_q;
  assign hi_md_o          = hi_q;
  assign lo_md_o          = lo_q;

endmodule
